mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Serialises an instruction-fetch port and a data port onto one memory interface.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the data port always wins ties.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr1,
    input  logic                  mem_read1,
    output logic [DATA_WIDTH-1:0] mem_rdata1,
    output logic                  mem_resp1,
    input  logic [ADDR_WIDTH-1:0] mem_addr2,
    input  logic                  mem_read2,
    input  logic                  mem_write2,
    input  logic [DATA_WIDTH-1:0] mem_wdata2,
    input  logic [1:0]            mem_byte_enable2,
    output logic [DATA_WIDTH-1:0] mem_rdata2,
    output logic                  mem_resp2,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [DATA_WIDTH-1:0] pmem_wdata,
    output logic [1:0]            pmem_byte_enable,
    input  logic [DATA_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {IDLE, BUSY1, BUSY2, DONE} state_t;

    state_t state, state_nxt;
    logic   pend1, pend2, win2;
    logic   grant1, grant2;

    assign pend1 = mem_read1;
    assign pend2 = mem_read2 | mem_write2;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 0: port 1 granted last, 1: port 2 granted last
    logic last_grant;

    assign win2 = pend2 & (~pend1 | ~last_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b0;
        end else if (grant2) begin
            last_grant <= 1'b1;
        end
    end
`else
    assign win2 = pend2;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decode
    always_comb begin
        state_nxt = state;
        grant1    = 1'b0;
        grant2    = 1'b0;
        case (state)
            IDLE: begin
                if (win2) begin
                    grant2    = 1'b1;
                    state_nxt = BUSY2;
                end else if (pend1) begin
                    grant1    = 1'b1;
                    state_nxt = BUSY1;
                end
            end
            BUSY1:   if (pmem_resp) state_nxt = DONE;
            BUSY2:   if (pmem_resp) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Response steering: pass-through only for the granted port in its resp cycle
    always_comb begin
        mem_resp1  = 1'b0;
        mem_resp2  = 1'b0;
        mem_rdata1 = '0;
        mem_rdata2 = '0;
        if (state == BUSY1 && pmem_resp) begin
            mem_resp1  = 1'b1;
            mem_rdata1 = pmem_rdata;
        end
        if (state == BUSY2 && pmem_resp) begin
            mem_resp2  = 1'b1;
            mem_rdata2 = pmem_rdata;
        end
    end

    // Physical request registers; a simultaneous read+write on port 2 is issued as a write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_addr        <= '0;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_wdata       <= '0;
            pmem_byte_enable <= 2'b00;
        end else if (grant2) begin
            pmem_addr        <= mem_addr2;
            pmem_read        <= mem_read2 & ~mem_write2;
            pmem_write       <= mem_write2;
            pmem_wdata       <= mem_wdata2;
            pmem_byte_enable <= mem_byte_enable2;
        end else if (grant1) begin
            pmem_addr        <= mem_addr1;
            pmem_read        <= 1'b1;
            pmem_write       <= 1'b0;
            pmem_wdata       <= '0;
            pmem_byte_enable <= 2'b11;
        end else if ((state == BUSY1 || state == BUSY2) && pmem_resp) begin
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
        end
    end

endmodule
